// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, exception codes,
// FSM states and the core-wide reset/stop constants.
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Stall vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb
  localparam logic [5:0] STALL_NONE       = 6'b000000;
  localparam logic [5:0] STALL_IF         = 6'b000011;
  localparam logic [5:0] STALL_ID         = 6'b000111;
  localparam logic [5:0] STALL_EX         = 6'b001111;
  localparam logic [5:0] STALL_MEM        = 6'b011111;
  localparam logic [5:0] STALL_EXC_BUBBLE = 6'b011111;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-high reset.
module pipe_ctrl_sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, two-phase exception entry (bubble,
// then registered flush with redirect PC), statistics and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [15:0] WDOG_LIMIT = 16'd1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t      state;
  logic        exc_take;
  logic        stall_any;
  logic        wdog_hit;
  logic [15:0] wdog_cnt;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    stall    = STALL_NONE;
    exc_take = 1'b0;
    if (state == ST_RUN) begin
      if (excepttype_i != ZERO_WORD) begin
        stall    = STALL_EXC_BUBBLE;
        exc_take = 1'b1;
      end else if (stallreq_from_mem == STOP) begin
        stall = STALL_MEM;
      end else if (stallreq_from_ex == STOP) begin
        stall = STALL_EX;
      end else if (stallreq_from_id == STOP) begin
        stall = STALL_ID;
      end else if (stallreq_from_if == STOP) begin
        stall = STALL_IF;
      end
    end
  end

  assign stall_any = (stall != STALL_NONE);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= ST_RUN;
      flush  <= 1'b0;
      new_pc <= ZERO_WORD;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_take) begin
            state  <= ST_FLUSH;
            flush  <= 1'b1;
            new_pc <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // The flag rises on the same edge the watchdog count reaches the limit.
  assign wdog_hit = stall_any && (wdog_cnt >= (WDOG_LIMIT - 16'd1));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_timeout <= 1'b0;
    end else if (wdog_hit) begin
      stall_timeout <= 1'b1;
    end
  end

  pipe_ctrl_sat_counter #(.W(16), .MAX(WDOG_LIMIT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .inc (stall_any),
    .clr (!stall_any || flush),
    .cnt (wdog_cnt)
  );

  pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clk (clk),
    .rst (rst),
    .inc (stall_any),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

  pipe_ctrl_sat_counter #(.W(CNT_W)) u_flush_count (
    .clk (clk),
    .rst (rst),
    .inc (exc_take),
    .clr (1'b0),
    .cnt (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception entry, ERET redirect,
// back-to-back exceptions, watchdog and reset during flush.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_LIMIT (16'd8),
    .CNT_W      (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    stallreq_from_if  = r_if;
    stallreq_from_id  = r_id;
    stallreq_from_ex  = r_ex;
    stallreq_from_mem = r_mem;
  endtask

  initial begin
    rst          = 1'b1;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
    set_req(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state, then one idle cycle
    check("rst_stall", {26'h0, stall}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_stall_cycles", stall_cycles, 32'h0);
    check("rst_flush_count", flush_count, 32'h0);
    check("rst_timeout", {31'h0, stall_timeout}, 32'h0);
    tick();
    check("idle_stall_cycles", stall_cycles, 32'h0);

    // id+ex together for three cycles
    set_req(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idex_stall", {26'h0, stall}, 32'h0000_000f);
      tick();
    end
    set_req(0, 0, 0, 0);
    #1;
    check("idex_stall_released", {26'h0, stall}, 32'h0);
    check("idex_stall_cycles", stall_cycles, 32'd3);

    // Priority encode, combinational only (no edge in between)
    set_req(1, 0, 0, 1); #1; check("prio_mem_if", {26'h0, stall}, 32'h0000_001f);
    set_req(1, 0, 1, 0); #1; check("prio_ex_if", {26'h0, stall}, 32'h0000_000f);
    set_req(1, 1, 0, 0); #1; check("prio_id_if", {26'h0, stall}, 32'h0000_0007);
    set_req(1, 0, 0, 0); #1; check("prio_if", {26'h0, stall}, 32'h0000_0003);
    set_req(0, 0, 0, 0); #1;
    tick();

    // Syscall with a concurrent mem stall request
    excepttype_i = 32'h8;
    set_req(0, 0, 0, 1);
    #1;
    check("exc_detect_stall", {26'h0, stall}, 32'h0000_001f);
    check("exc_detect_flush", {31'h0, flush}, 32'h0);
    tick();
    excepttype_i = 32'h0;
    #1;
    check("exc_flush", {31'h0, flush}, 32'h1);
    check("exc_flush_stall_ignores_mem", {26'h0, stall}, 32'h0);
    check("exc_new_pc", new_pc, 32'h0000_0020);
    check("exc_flush_count", flush_count, 32'd1);
    check("exc_stall_cycles", stall_cycles, 32'd4);
    tick();
    check("exc_after_flush", {31'h0, flush}, 32'h0);
    check("exc_after_new_pc", new_pc, 32'h0000_0020);
    check("exc_after_run_stall", {26'h0, stall}, 32'h0000_001f);
    set_req(0, 0, 0, 0);
    #1;
    check("exc_after_stall_cycles", stall_cycles, 32'd4);
    tick();

    // ERET redirects to the EPC
    excepttype_i = 32'he;
    cp0_epc_i    = 32'h0000_1234;
    #1;
    check("eret_detect_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
    #1;
    check("eret_flush", {31'h0, flush}, 32'h1);
    check("eret_new_pc", new_pc, 32'h0000_1234);
    check("eret_flush_count", flush_count, 32'd2);
    tick();
    check("eret_after_flush", {31'h0, flush}, 32'h0);
    check("eret_new_pc_hold", new_pc, 32'h0000_1234);

    // Exception held for four cycles: detect, FLUSH, detect, FLUSH
    excepttype_i = 32'h1;
    #1;
    check("b2b_c0_flush", {31'h0, flush}, 32'h0);
    check("b2b_c0_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    check("b2b_c1_flush", {31'h0, flush}, 32'h1);
    check("b2b_c1_stall", {26'h0, stall}, 32'h0);
    tick();
    check("b2b_c2_flush", {31'h0, flush}, 32'h0);
    check("b2b_c2_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    check("b2b_c3_flush", {31'h0, flush}, 32'h1);
    check("b2b_new_pc", new_pc, 32'h0000_0020);
    excepttype_i = 32'h0;
    #1;
    check("b2b_flush_count", flush_count, 32'd4);
    check("b2b_stall_cycles", stall_cycles, 32'd7);
    tick();
    check("b2b_end_flush", {31'h0, flush}, 32'h0);

    // Watchdog with limit 8: flag rises on the 8th stalled edge and sticks
    set_req(1, 0, 0, 0);
    #1;
    check("wdog_stall", {26'h0, stall}, 32'h0000_0003);
    for (int i = 0; i < 7; i++) tick();
    check("wdog_before_limit", {31'h0, stall_timeout}, 32'h0);
    tick();
    check("wdog_at_limit", {31'h0, stall_timeout}, 32'h1);
    set_req(0, 0, 0, 0);
    tick();
    tick();
    check("wdog_sticky", {31'h0, stall_timeout}, 32'h1);
    check("wdog_stall_cycles", stall_cycles, 32'd15);

    // Reset while in FLUSH
    excepttype_i = 32'ha;
    tick();
    excepttype_i = 32'h0;
    rst = 1'b1;
    #1;
    check("rstf_flush_before_edge", {31'h0, flush}, 32'h1);
    check("rstf_flush_count_before", flush_count, 32'd5);
    tick();
    check("rstf_flush", {31'h0, flush}, 32'h0);
    check("rstf_new_pc", new_pc, 32'h0);
    check("rstf_stall", {26'h0, stall}, 32'h0);
    check("rstf_timeout", {31'h0, stall_timeout}, 32'h0);
    check("rstf_stall_cycles", stall_cycles, 32'h0);
    check("rstf_flush_count", flush_count, 32'h0);
    rst = 1'b0;

    // Sequencer is back in RUN and accepts a fresh exception
    excepttype_i = 32'hc;
    #1;
    check("post_rst_detect", {26'h0, stall}, 32'h0000_001f);
    tick();
    excepttype_i = 32'h0;
    #1;
    check("post_rst_flush", {31'h0, flush}, 32'h1);
    check("post_rst_flush_count", flush_count, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
